// File: rtl/booth_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | booth_pkg : shared state encoding and parameter helpers for the  |
// |             sequential Booth multiplier.          Rev 1.0        |
// +------------------------------------------------------------------+
package booth_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CALC   = 3'd3,
    OUT_HI = 3'd4,
    OUT_LO = 3'd5
  } state_t;

  function automatic bit radix_ok(input int radix);
    return (radix == 2) || (radix == 4);
  endfunction

  function automatic bit width_ok(input int w);
    return (w >= 4) && ((w % 2) == 0);
  endfunction

  // Number of CALC cycles: one per extended multiplier bit, or one per pair.
  function automatic int iter_count(input int w, input int radix);
    return (radix == 4) ? (w + 2) / 2 : (w + 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_recoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | booth_recoder : maps a Booth triplet to a digit magnitude and a  |
// |                 negate flag.                      Rev 1.0        |
// +------------------------------------------------------------------+
module booth_recoder (
  input  logic [2:0] trip,
  output logic [1:0] mag,
  output logic       neg
);

  always_comb begin
    mag = 2'd0;
    neg = 1'b0;
    case (trip)
      3'b001, 3'b010: mag = 2'd1;
      3'b011:         mag = 2'd2;
      3'b100: begin
        mag = 2'd2;
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        mag = 2'd1;
        neg = 1'b1;
      end
      default: begin
        mag = 2'd0;
        neg = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/booth_mult_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | booth_mult_param : sequential radix-2/4 Booth multiplier with a  |
// |                    shared operand/result bus.     Rev 1.0        |
// +------------------------------------------------------------------+
module booth_mult_param
  import booth_pkg::*;
#(
  parameter int W     = 8,
  parameter int RADIX = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sgn,
  input  logic [W-1:0] inbus,
  output logic [W-1:0] outbus,
  output logic         done,
  output logic         busy
);

  localparam int c_EW = W + 2;
  localparam int c_AW = W + 4;
  localparam int c_N  = iter_count(W, RADIX);
  localparam int c_CW = $clog2(c_N + 1);
  localparam int c_SH = (RADIX == 4) ? 2 : 1;

  generate
    if (!radix_ok(RADIX)) begin : g_bad_radix
      $error("booth_mult_param: RADIX must be 2 or 4");
    end
    if (!width_ok(W)) begin : g_bad_width
      $error("booth_mult_param: W must be even and at least 4");
    end
  endgenerate

  state_t            r_state;
  state_t            w_next;
  logic              r_sgn;
  logic [c_EW-1:0]   r_a;
  logic [c_AW-1:0]   r_acc;
  logic [c_EW-1:0]   r_mul;
  logic              r_prev;
  logic [c_CW-1:0]   r_cnt;

  logic [c_EW-1:0]      w_in_ext;
  logic [c_AW-1:0]      w_a_ext;
  logic [c_AW-1:0]      w_addend;
  logic [c_AW-1:0]      w_sum;
  logic [c_AW+c_EW-1:0] w_cat;
  logic [c_AW+c_EW-1:0] w_shift;
  logic [2:0]           w_trip;
  logic [1:0]           w_mag;
  logic                 w_neg;
  logic [2*W-1:0]       w_prod;

  assign w_in_ext = {{2{r_sgn & inbus[W-1]}}, inbus};

  // Radix-2 repeats b(i) so the same recoder yields only 0 / +-A.
  generate
    if (RADIX == 4) begin : g_r4
      assign w_trip = {r_mul[1], r_mul[0], r_prev};
    end else begin : g_r2
      assign w_trip = {r_mul[0], r_mul[0], r_prev};
    end
  endgenerate

  booth_recoder u_recoder (
    .trip (w_trip),
    .mag  (w_mag),
    .neg  (w_neg)
  );

  // Two headroom bits above the W+2 operand keep +-2A partial sums exact.
  assign w_a_ext  = {{2{r_a[c_EW-1]}}, r_a};
  assign w_addend = (w_mag == 2'd2) ? (w_a_ext << 1) :
                    (w_mag == 2'd1) ? w_a_ext : '0;
  assign w_sum    = w_neg ? (r_acc - w_addend) : (r_acc + w_addend);
  assign w_cat    = {w_sum, r_mul};
  assign w_shift  = $signed(w_cat) >>> c_SH;
  assign w_prod   = {r_acc[W-3:0], r_mul};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = LOAD_A;
      LOAD_A:  w_next = LOAD_B;
      LOAD_B:  w_next = CALC;
      CALC:    if (r_cnt == c_CW'(1)) w_next = OUT_HI;
      OUT_HI:  w_next = OUT_LO;
      OUT_LO:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sgn  <= 1'b0;
      r_a    <= '0;
      r_acc  <= '0;
      r_mul  <= '0;
      r_prev <= 1'b0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) r_sgn <= sgn;
        end
        LOAD_A: begin
          r_a <= w_in_ext;
        end
        LOAD_B: begin
          r_mul  <= w_in_ext;
          r_acc  <= '0;
          r_prev <= 1'b0;
          r_cnt  <= c_CW'(c_N);
        end
        CALC: begin
          {r_acc, r_mul} <= w_shift;
          r_prev         <= r_mul[c_SH-1];
          r_cnt          <= r_cnt - c_CW'(1);
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  always_comb begin
    outbus = '0;
    done   = 1'b0;
    busy   = (r_state != IDLE);
    case (r_state)
      OUT_HI: begin
        outbus = w_prod[2*W-1:W];
        done   = 1'b1;
      end
      OUT_LO: begin
        outbus = w_prod[W-1:0];
        done   = 1'b1;
      end
      default: begin
        outbus = '0;
        done   = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
